// File: rtl/sift_ctrl_pkg.sv
// sift_ctrl_pkg: shared constants and state encoding for the SIFT front-end control blocks
package sift_ctrl_pkg;
  localparam int IMG_ROWS = 480;
  localparam int ADDR_W = 9;
  localparam int N_BLUR_ENG = 4;
  localparam int ENG_3X3 = 0;
  localparam int ENG_5X5_1 = 1;
  localparam int ENG_5X5_2 = 2;
  localparam int ENG_7X7 = 3;
  typedef enum logic [2:0] {IDLE, FETCH, SHIFT, DISPATCH, WAIT, DONE} blur_state_e;
endpackage

// File: rtl/blur_row_scheduler_if.sv
// blur_row_scheduler_if: start/abort control, engine handshake and line-buffer feed of the row scheduler
interface blur_row_scheduler_if #(
  parameter int N_ENG = sift_ctrl_pkg::N_BLUR_ENG,
  parameter int ADDR_W = sift_ctrl_pkg::ADDR_W
) ();
  logic start_i, abort_i;
  logic [N_ENG-1:0] eng_mask_i, eng_ack_i, row_valid_o;
  logic [ADDR_W-1:0] img_addr_o, row_idx_o;
  logic buffer_we_o, busy_o, done_o;
  modport master (
    output start_i, abort_i, eng_mask_i, eng_ack_i,
    input img_addr_o, buffer_we_o, row_valid_o, row_idx_o, busy_o, done_o
  );
  modport slave (
    input start_i, abort_i, eng_mask_i, eng_ack_i,
    output img_addr_o, buffer_we_o, row_valid_o, row_idx_o, busy_o, done_o
  );
endinterface

// File: rtl/blur_row_scheduler_ack.sv
// blur_ack_collector: tracks which dispatched engines still owe an ack for the current row
module blur_ack_collector #(
  parameter int N_ENG = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic load_i,
  input  logic track_i,
  input  logic [N_ENG-1:0] mask_i,
  input  logic [N_ENG-1:0] ack_i,
  output logic all_done_o
);
  logic [N_ENG-1:0] pending_q, pending_d;
  always_comb pending_d = load_i ? mask_i & ~ack_i : track_i ? pending_q & ~ack_i : pending_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) pending_q <= '0;
    else pending_q <= pending_d;
  end
  // an ack arriving this cycle already counts, so the FSM can leave WAIT without an extra cycle
  assign all_done_o = (pending_q & ~ack_i) == '0;
endmodule

// File: rtl/blur_row_scheduler.sv
// blur_row_scheduler: streams image rows into the line buffer and dispatches each row window to the blur engines
module blur_row_scheduler #(
  parameter int ROWS = sift_ctrl_pkg::IMG_ROWS,
  parameter int PRIME_ROWS = 6,
  parameter int ADDR_W = sift_ctrl_pkg::ADDR_W,
  parameter int N_ENG = sift_ctrl_pkg::N_BLUR_ENG
) (
  input logic clk,
  input logic rst,
  blur_row_scheduler_if.slave bus
);
  import sift_ctrl_pkg::*;
  localparam logic [ADDR_W-1:0] LAST_PRIME = ADDR_W'(PRIME_ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);
  blur_state_e state_q;
  logic [ADDR_W-1:0] r_q, img_addr_q, row_idx_q;
  logic [N_ENG-1:0] mask_q, row_valid_q;
  logic buffer_we_q, busy_q, done_q, all_done;
  blur_ack_collector #(.N_ENG(N_ENG)) u_ack (
    .clk(clk),
    .rst(rst),
    .clr_i(bus.abort_i),
    .load_i(state_q == DISPATCH),
    .track_i(state_q == WAIT),
    .mask_i(mask_q),
    .ack_i(bus.eng_ack_i),
    .all_done_o(all_done)
  );
  // outputs are loaded on the transition into a state so they are valid for that state's whole cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q <= '0;
      mask_q <= '0;
      img_addr_q <= '0;
      row_idx_q <= '0;
      row_valid_q <= '0;
      buffer_we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else if (bus.abort_i) begin
      state_q <= IDLE;
      r_q <= '0;
      img_addr_q <= '0;
      row_idx_q <= '0;
      row_valid_q <= '0;
      buffer_we_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      buffer_we_q <= 1'b0;
      row_valid_q <= '0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start_i) begin
          state_q <= FETCH;
          r_q <= '0;
          mask_q <= bus.eng_mask_i;
          img_addr_q <= '0;
          busy_q <= 1'b1;
        end
        FETCH: begin
          state_q <= SHIFT;
          buffer_we_q <= 1'b1;
        end
        SHIFT: if (r_q < LAST_PRIME) begin
          state_q <= FETCH;
          r_q <= r_q + 1'b1;
          img_addr_q <= r_q + 1'b1;
        end else begin
          state_q <= DISPATCH;
          row_valid_q <= mask_q;
          row_idx_q <= r_q - LAST_PRIME;
        end
        DISPATCH: state_q <= WAIT;
        WAIT: if (all_done && r_q == LAST_ROW) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end else if (all_done) begin
          state_q <= FETCH;
          r_q <= r_q + 1'b1;
          img_addr_q <= r_q + 1'b1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
          img_addr_q <= '0;
          row_idx_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.img_addr_o = img_addr_q;
  assign bus.buffer_we_o = buffer_we_q;
  assign bus.row_valid_o = row_valid_q;
  assign bus.row_idx_o = row_idx_q;
  assign bus.busy_o = busy_q;
  assign bus.done_o = done_q;
endmodule

// File: tb/tb_blur_row_scheduler.sv
// tb_blur_row_scheduler: compares every cycle of a pass against a row-schedule model built from the timing rules
module tb_blur_row_scheduler;
  import sift_ctrl_pkg::*;
  typedef struct packed {
    logic [8:0] addr;
    logic we;
    logic [3:0] rv;
    logic [8:0] idx;
    logic busy;
    logic done;
  } obs_t;
  typedef struct {
    int sel;
    logic [3:0] mask;
    int mode;
    logic [3:0] spur;
    int spam;
    int n_we;
    int n_rv;
    int t_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, sel = 1'b0;
  logic [3:0] mask = '0, ack = '0;
  int errors = 0, checks = 0;
  int dly [480][4];
  int wait_at [480];
  logic [3:0] ack_plan [4096];
  obs_t expq [$];
  obs_t obs_a, obs_b, obs;

  always #5 clk = ~clk;

  blur_row_scheduler_if #(.N_ENG(4), .ADDR_W(9)) if_a ();
  blur_row_scheduler_if #(.N_ENG(4), .ADDR_W(9)) if_b ();
  blur_row_scheduler u_a (.clk(clk), .rst(rst), .bus(if_a));
  blur_row_scheduler #(.ROWS(8), .PRIME_ROWS(3)) u_b (.clk(clk), .rst(rst), .bus(if_b));

  assign if_a.start_i = start & ~sel;
  assign if_b.start_i = start & sel;
  assign if_a.abort_i = abort & ~sel;
  assign if_b.abort_i = abort & sel;
  assign if_a.eng_mask_i = mask;
  assign if_b.eng_mask_i = mask;
  assign if_a.eng_ack_i = sel ? 4'h0 : ack;
  assign if_b.eng_ack_i = sel ? ack : 4'h0;
  assign obs_a = {if_a.img_addr_o, if_a.buffer_we_o, if_a.row_valid_o, if_a.row_idx_o, if_a.busy_o, if_a.done_o};
  assign obs_b = {if_b.img_addr_o, if_b.buffer_we_o, if_b.row_valid_o, if_b.row_idx_o, if_b.busy_o, if_b.done_o};
  assign obs = sel ? obs_b : obs_a;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // ack delay of each engine, in cycles after its row's DISPATCH
  task automatic set_dly(input int mode);
    int st [4];
    st[ENG_3X3] = 1;
    st[ENG_5X5_1] = 3;
    st[ENG_5X5_2] = 3;
    st[ENG_7X7] = 6;
    foreach (dly[r, e]) dly[r][e] = mode == 0 ? 0 : mode == 1 ? st[e] : int'($urandom_range(0, 4));
  endtask

  // expq[k-1] holds the outputs required in cycle k (start sampled at edge 0)
  task automatic build(input int rows, input int prime, input logic [3:0] m);
    logic [8:0] idx;
    int w;
    idx = '0;
    expq.delete();
    foreach (ack_plan[i]) ack_plan[i] = '0;
    for (int r = 0; r < rows; r++) begin
      expq.push_back({9'(r), 1'b0, 4'h0, idx, 1'b1, 1'b0});
      expq.push_back({9'(r), 1'b1, 4'h0, idx, 1'b1, 1'b0});
      if (r >= prime - 1) begin
        idx = 9'(r - prime + 1);
        expq.push_back({9'(r), 1'b0, m, idx, 1'b1, 1'b0});
        wait_at[r] = expq.size() + 1;
        w = 1;
        for (int e = 0; e < 4; e++) if (m[e]) begin
          w = dly[r][e] > w ? dly[r][e] : w;
          ack_plan[expq.size() + dly[r][e]][e] = 1'b1;
          ack_plan[expq.size() + dly[r][e] + 1][e] = 1'b1;
        end
        for (int c = 0; c < w; c++) expq.push_back({9'(r), 1'b0, 4'h0, idx, 1'b1, 1'b0});
      end
    end
    expq.push_back({9'(rows - 1), 1'b0, 4'h0, idx, 1'b1, 1'b1});
    expq.push_back('0);
  endtask

  task automatic run_pass(input string name, input vec_t v, input int abort_row);
    obs_t o;
    int n_we, n_rv, t_done, n, kab, e0;
    n_we = 0;
    n_rv = 0;
    t_done = -1;
    e0 = errors;
    sel = (v.sel != 0);
    mask = v.mask;
    set_dly(v.mode);
    build(sel ? 8 : 480, sel ? 3 : 6, v.mask);
    n = expq.size();
    kab = abort_row < 0 ? 0 : wait_at[abort_row];
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      start = (v.spam != 0) && k < n && $urandom_range(0, 2) == 0;
      ack = ack_plan[k] | v.spur;
      o = obs;
      n_we += int'(o.we);
      n_rv += int'(o.rv != 4'h0);
      if (o.done) t_done = k;
      if (errors - e0 < 5) check($sformatf("%s cycle %0d", name, k), 32'(o), 32'(expq[k-1]));
      if (k == kab) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        ack = '0;
        check($sformatf("%s after abort", name), 32'(obs), 32'h0);
        @(negedge clk);
        check($sformatf("%s idle after abort", name), 32'(obs), 32'h0);
        return;
      end
    end
    start = 1'b0;
    ack = '0;
    if (v.n_we >= 0) check($sformatf("%s buffer_we count", name), n_we, v.n_we);
    if (v.n_rv >= 0) check($sformatf("%s row_valid count", name), n_rv, v.n_rv);
    if (v.t_done >= 0) check($sformatf("%s done cycle", name), t_done, v.t_done);
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{0, 4'hF, 0, 4'h0, 0, 480, 475, 1911};
    tbl[1] = '{1, 4'hF, 1, 4'h0, 0, 8, 6, 59};
    tbl[2] = '{1, 4'h5, 1, 4'hA, 0, 8, 6, 41};
    tbl[3] = '{1, 4'h0, 0, 4'h0, 0, 8, 0, 29};
    tbl[4] = '{1, 4'hF, 2, 4'h0, 1, 8, 6, -1};
    tbl[5] = '{1, 4'h9, 0, 4'h6, 1, 8, 6, 29};
    repeat (3) @(negedge clk);
    check("reset outputs A", 32'(obs_a), 32'h0);
    check("reset outputs B", 32'(obs_b), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      run_pass($sformatf("vec%0d", i), tbl[i], -1);
      repeat (2) @(negedge clk);
    end
    sel = 1'b1;
    mask = 4'hF;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start+abort idle", 32'(obs), 32'h0);
    @(negedge clk);
    check("start+abort stays idle", 32'(obs), 32'h0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("shift before rst", 32'(obs.we), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("rst in shift", 32'(obs), 32'h0);
    rst = 1'b0;
    run_pass("after rst", tbl[1], -1);
    repeat (2) @(negedge clk);
    run_pass("abort row 200", tbl[0], 200);
    for (int i = 0; i < 4; i++) begin
      vec_t v;
      v.sel = (i != 0) ? 1 : 0;
      v.mask = 4'($urandom);
      v.mode = 2;
      v.spur = ~v.mask & 4'($urandom);
      v.spam = 1;
      v.n_we = (i != 0) ? 8 : 480;
      v.n_rv = (v.mask == 4'h0) ? 0 : (i != 0) ? 6 : 475;
      v.t_done = -1;
      run_pass($sformatf("rand%0d", i), v, -1);
      repeat (2) @(negedge clk);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
